// File: rtl/syscall_ctrl.sv
// ---------------------------------------------------------------------------
// syscall_ctrl
//
// Multi-cycle sequencer that sits behind the syscall instruction of the
// single-cycle MIPS core. When the decoder flags a syscall (Enable), the
// service code ($v0) and argument ($a0) are captured and the core is frozen
// (Stall) while the service runs:
//   code 1  : print-int  - Hex takes the argument and is held on screen for
//                          HOLD_CYCLES cycles with the core still stalled.
//   code 11 : print-char - Char takes the low byte of the argument and
//                          CharValid strobes for one cycle.
//   code 10 : exit       - Halt is set and the core stays stalled until reset.
//   other   : unknown    - sticky Err is set, the syscall otherwise retires.
// Completion is reported with a one-cycle Done pulse, in a cycle where Stall
// is low, so the core retires the syscall on that same edge.
//
// Handshake: Enable is a level request that the core keeps high for as long
// as Stall holds it on the syscall instruction. The controller accepts it in
// IDLE only. Done is the single-cycle completion strobe; the Enable still
// present in the Done cycle belongs to the retiring syscall and is ignored.
// A new request is only recognised once the controller is back in IDLE.
//
// Parameters
//   HOLD_CYCLES  cycles Hex is held with the core stalled (must be >= 1)
//   CNT_W        width of SyscallCount
//
// Ports
//   clk           in   1      system clock, rising edge
//   reset         in   1      synchronous reset, active low
//   Enable        in   1      syscall decoded this cycle (held while stalled)
//   v0            in   32     service code
//   a0            in   32     service argument
//   Stall         out  1      freeze PC / register file writes this cycle
//   Done          out  1      one-cycle pulse, syscall may retire
//   Halt          out  1      sticky, exit service executed
//   Hex           out  32     last print-int argument
//   Char          out  8      last print-char byte
//   CharValid     out  1      one-cycle strobe, Char updated
//   Err           out  1      sticky, unknown service code seen
//   SyscallCount  out  CNT_W  completed syscalls (exit included), saturating
//   dbg_state     out  3      current sequencer state, for observation only
// ---------------------------------------------------------------------------
module syscall_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Enable,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    output logic             Stall,
    output logic             Done,
    output logic             Halt,
    output logic [31:0]      Hex,
    output logic [7:0]       Char,
    output logic             CharValid,
    output logic             Err,
    output logic [CNT_W-1:0] SyscallCount,
    output logic [2:0]       dbg_state
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EXEC   = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    // Service codes understood by this controller.
    localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

    // The hold counter runs HOLD_CYCLES-1 down to 0, so it needs enough bits
    // for HOLD_CYCLES-1 and at least one bit when HOLD_CYCLES is 1.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [31:0]       code_q;
    logic [31:0]       arg_q;
    logic [HOLD_W-1:0] hold_cnt;

    // Decoded service of the latched request.
    logic is_print_int;
    logic is_print_char;
    logic is_exit;
    logic is_unknown;

    // A syscall counts as completed when it retires (DONE) or when exit
    // executes, since exit never reaches DONE.
    logic count_event;
    logic count_full;

    assign is_print_int  = (code_q == SVC_PRINT_INT);
    assign is_print_char = (code_q == SVC_PRINT_CHAR);
    assign is_exit       = (code_q == SVC_EXIT);
    assign is_unknown    = !(is_print_int || is_print_char || is_exit);

    assign count_event = (state == S_DONE) || ((state == S_EXEC) && is_exit);
    assign count_full  = (SyscallCount == {CNT_W{1'b1}});

    assign dbg_state = state;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Enable) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_print_int) begin
                    state_nxt = S_HOLD;
                end else if (is_exit) begin
                    state_nxt = S_HALTED;
                end else begin
                    // print-char and unknown codes both retire right away.
                    state_nxt = S_DONE;
                end
            end
            S_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Enable here is still the retiring syscall; never re-arm.
                state_nxt = S_IDLE;
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Handshake outputs
    // -----------------------------------------------------------------------
    // In IDLE the stall follows Enable combinationally so the request cycle
    // itself never advances the PC. The request term is masked while reset
    // is asserted so a held Enable does not show up as a stall during reset.
    always_comb begin
        Stall = 1'b0;
        Done  = 1'b0;
        case (state)
            S_IDLE:   Stall = Enable && reset;
            S_EXEC:   Stall = 1'b1;
            S_HOLD:   Stall = 1'b1;
            S_DONE:   Done  = 1'b1;
            S_HALTED: Stall = 1'b1;
            default: begin
                Stall = 1'b0;
                Done  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, request latch and service datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            code_q       <= '0;
            arg_q        <= '0;
            hold_cnt     <= '0;
            Halt         <= 1'b0;
            Hex          <= '0;
            Char         <= '0;
            CharValid    <= 1'b0;
            Err          <= 1'b0;
            SyscallCount <= '0;
        end else begin
            state     <= state_nxt;
            // Strobe: high only in the cycle after EXEC of a print-char.
            CharValid <= 1'b0;

            // Capture only on acceptance, so later v0/a0 changes cannot
            // disturb the running service.
            if ((state == S_IDLE) && Enable) begin
                code_q <= v0;
                arg_q  <= a0;
            end

            if (state == S_EXEC) begin
                if (is_print_int) begin
                    Hex      <= arg_q;
                    hold_cnt <= HOLD_LAST;
                end
                if (is_print_char) begin
                    Char      <= arg_q[7:0];
                    CharValid <= 1'b1;
                end
                if (is_exit) begin
                    Halt <= 1'b1;
                end
                if (is_unknown) begin
                    Err <= 1'b1;
                end
            end

            // The HOLD state lasts until the counter has reached zero, which
            // gives exactly HOLD_CYCLES cycles starting from HOLD_LAST.
            if ((state == S_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end

            if (count_event && !count_full) begin
                SyscallCount <= SyscallCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_syscall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_syscall_ctrl
//
// Self-checking bench for syscall_ctrl. A reference model predicts, for each
// syscall, how long the core is stalled, when Done fires and how the visible
// status (Hex, Char, Err, Halt, SyscallCount) evolves, computed directly from
// the service rules. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_syscall_ctrl;

    localparam int HOLD    = 4;
    localparam int CNT_W   = 3;      // small so saturation is reachable
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic             clk = 1'b0;
    logic             reset;
    logic             Enable;
    logic [31:0]      v0;
    logic [31:0]      a0;
    logic             Stall;
    logic             Done;
    logic             Halt;
    logic [31:0]      Hex;
    logic [7:0]       Char;
    logic             CharValid;
    logic             Err;
    logic [CNT_W-1:0] SyscallCount;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    syscall_ctrl #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Enable       (Enable),
        .v0           (v0),
        .a0           (a0),
        .Stall        (Stall),
        .Done         (Done),
        .Halt         (Halt),
        .Hex          (Hex),
        .Char         (Char),
        .CharValid    (CharValid),
        .Err          (Err),
        .SyscallCount (SyscallCount),
        .dbg_state    (dbg_state)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state and reference model
    // -----------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hex;
    logic [7:0]  m_char;
    logic        m_err;
    int          m_count;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    task automatic model_reset();
        m_hex   = '0;
        m_char  = '0;
        m_err   = 1'b0;
        m_count = 0;
    endtask

    // Check the status outputs that do not depend on the cycle position.
    task automatic check_status(input string tag);
        check({tag, ".hex"},   Hex,                 m_hex);
        check({tag, ".char"},  32'(Char),           32'(m_char));
        check({tag, ".err"},   32'(Err),            32'(m_err));
        check({tag, ".count"}, 32'(SyscallCount),   32'(m_count));
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks. Each starts from the falling edge of an idle cycle and
    // returns at the falling edge of an idle cycle.
    // -----------------------------------------------------------------------

    // Non-exit syscall. Latency L (request cycle = 0): print-int holds the
    // display for HOLD cycles after one execute cycle, so L = HOLD+2; all
    // others finish in L = 2. Stall is high for cycles 0..L-1, Done in L.
    task automatic run_syscall(input logic [31:0] code, input logic [31:0] arg);
        int  lat;
        bit  pint, pchar, unk;
        pint  = (code == 32'd1);
        pchar = (code == 32'd11);
        unk   = !(pint || pchar);
        lat   = pint ? HOLD + 2 : 2;

        @(posedge clk); #1;
        Enable = 1'b1;
        v0     = code;
        a0     = arg;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check("stall", 32'(Stall), 32'(k < lat));
            check("done",  32'(Done),  32'(k == lat));
            check("halt",  32'(Halt),  32'(0));
            check("cvalid", 32'(CharValid), 32'(pchar && (k == 2)));
            check("hex",  Hex, (pint && k >= 2) ? arg : m_hex);
            check("char", 32'(Char), 32'((pchar && k >= 2) ? arg[7:0] : m_char));
            check("err",  32'(Err),  32'((unk && k >= 2) ? 1'b1 : m_err));
            check("count", 32'(SyscallCount), 32'(m_count));
            @(posedge clk); #1;
            // Scramble the request operands after they have been latched.
            if (k == 0) begin
                v0 = $urandom;
                a0 = $urandom;
            end
        end
        // Enable stayed high through the Done cycle; it must be ignored.
        Enable = 1'b0;
        if (pint)  m_hex  = arg;
        if (pchar) m_char = arg[7:0];
        if (unk)   m_err  = 1'b1;
        m_count = sat_inc(m_count);
        @(negedge clk);
        check("idle.stall",  32'(Stall),     32'(0));
        check("idle.done",   32'(Done),      32'(0));
        check("idle.cvalid", 32'(CharValid), 32'(0));
        check_status("idle");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            Enable = 1'b0;
            v0     = $urandom;
            @(negedge clk);
            check("gap.stall", 32'(Stall), 32'(0));
            check("gap.done",  32'(Done),  32'(0));
        end
    endtask

    // Synchronous reset held for n edges, then released with Enable low.
    task automatic apply_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
        reset  = 1'b1;
        Enable = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst.stall", 32'(Stall), 32'(0));
        check("rst.done",  32'(Done),  32'(0));
        check("rst.halt",  32'(Halt),  32'(0));
        check("rst.cvalid", 32'(CharValid), 32'(0));
        check_status("rst");
    endtask

    // Exit: stalled forever from the request on, Halt and the count update
    // from cycle 2, later requests of any kind are ignored.
    task automatic run_exit(input logic [31:0] arg);
        int exp_count;
        exp_count = sat_inc(m_count);
        @(posedge clk); #1;
        Enable = 1'b1;
        v0     = 32'd10;
        a0     = arg;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("exit.stall", 32'(Stall), 32'(1));
            check("exit.done",  32'(Done),  32'(0));
            check("exit.halt",  32'(Halt),  32'(k >= 2));
            check("exit.count", 32'(SyscallCount), 32'((k >= 2) ? exp_count : m_count));
            check("exit.hex",   Hex, m_hex);
            check("exit.cvalid", 32'(CharValid), 32'(0));
            @(posedge clk); #1;
            if (k >= 1) begin
                Enable = 1'($urandom_range(0, 1));
                v0     = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'd11;
                a0     = $urandom;
            end
        end
        m_count = exp_count;
        check_status("halted");
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    logic [31:0] rc;
    logic [31:0] ra;

    initial begin
        reset  = 1'b0;
        Enable = 1'b1;
        v0     = 32'd1;
        a0     = 32'hCAFE_F00D;
        model_reset();

        // Reset with a request pending: nothing may start or stall.
        @(posedge clk); #1;
        @(negedge clk);
        check("inrst.stall", 32'(Stall), 32'(0));
        check("inrst.done",  32'(Done),  32'(0));
        check("inrst.halt",  32'(Halt),  32'(0));
        check_status("inrst");
        @(posedge clk); #1;
        reset  = 1'b1;
        Enable = 1'b0;
        @(negedge clk);
        check("rel.stall", 32'(Stall), 32'(0));
        check("rel.done",  32'(Done),  32'(0));
        check_status("rel");
        idle_cycles(2);

        // Directed services.
        run_syscall(32'd1,  32'h1234_5678);
        run_syscall(32'd11, 32'h0000_0041);
        run_syscall(32'd5,  32'h0000_0000);
        idle_cycles(1);

        // Reset in the middle of the display hold.
        @(posedge clk); #1;
        Enable = 1'b1;
        v0     = 32'd1;
        a0     = 32'hA5A5_5A5A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid.stall", 32'(Stall), 32'(1));
            @(posedge clk); #1;
        end
        reset = 1'b0;                    // cycle 3, inside the hold
        @(negedge clk);
        check("mid.hex", Hex, 32'hA5A5_5A5A);
        @(posedge clk); #1;
        reset  = 1'b1;
        Enable = 1'b0;
        model_reset();
        for (int k = 0; k < HOLD + 3; k++) begin
            @(negedge clk);
            check("mid.done",  32'(Done),  32'(0));
            check("mid.stall", 32'(Stall), 32'(0));
            check_status("mid");
            @(posedge clk); #1;
        end
        @(negedge clk);

        // Random mix of services; long enough to saturate SyscallCount.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0: rc = 32'd1;
                1: rc = 32'd11;
                default: begin
                    do begin
                        rc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
                    end while (rc == 32'd1 || rc == 32'd10 || rc == 32'd11);
                end
            endcase
            ra = $urandom;
            run_syscall(rc, ra);
            idle_cycles($urandom_range(0, 2));
        end
        check("sat.count", 32'(SyscallCount), 32'(CNT_MAX));

        // Exit with the counter saturated, then from a fresh reset.
        run_exit(32'hDEAD_BEEF);
        apply_reset(1);
        run_syscall(32'd1, 32'h0BAD_F00D);
        run_exit(32'hDEAD_BEEF);
        apply_reset(2);
        run_syscall(32'd11, $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the stimulus is clock-bounded, this only guards against a
    // broken clock or an unexpected stall of the simulation itself.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
